servo_array_ctrl: RTL

//  Multi-channel successor of the single-servo driver. Decodes position/storage command bytes from the

---
 rtl/servo_pkg.sv | 34 +++
 rtl/servo_array_ctrl_if.sv | 10 +
 rtl/servo_pwm_channel.sv | 44 ++++
 rtl/servo_array_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared constants and command-byte classification for the servo gate array.
package servo_pkg;

    localparam int unsigned POS_MIN = 1;
    localparam int unsigned POS_MAX = 16;
    localparam int unsigned STO_MIN = 103;
    localparam int unsigned STO_MAX = 113;
    localparam int unsigned STO_OFS = 100;

    localparam int unsigned DEF_PERIOD_CYC  = 1000000;
    localparam int unsigned DEF_OPEN_CYC    = 35000;
    localparam int unsigned DEF_REST_CYC    = 110000;
    localparam int unsigned DEF_STEP_CYC    = 5000;
    localparam logic [15:0] DEF_MATCH_MASK  = 16'h3BB8;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_POS,
        CMD_STO,
        CMD_ERR
    } cmd_kind_e;

    function automatic cmd_kind_e classify(input logic [7:0] code);
        cmd_kind_e kind;
        kind = CMD_ERR;
        if (32'(code) >= POS_MIN && 32'(code) <= POS_MAX) begin
            kind = CMD_POS;
        end else if (32'(code) >= STO_MIN && 32'(code) <= STO_MAX) begin
            kind = CMD_STO;
        end
        return kind;
    endfunction

endpackage

// File: rtl/servo_array_ctrl_if.sv
// Received-byte stream from the UART receiver into the servo array controller.
interface servo_array_ctrl_if;

    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input  rx_data, input  rx_valid);

endinterface

// File: rtl/servo_pwm_channel.sv
// One servo output: frame-synchronous slew-limited width register and PWM compare.
module servo_pwm_channel #(
    parameter int unsigned CW       = 20,
    parameter int unsigned REST_CYC = 110000,
    parameter int unsigned STEP_CYC = 5000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] frame_cnt,
    input  logic          frame_wrap,
    input  logic [CW-1:0] target,
    output logic          pwm,
    output logic          at_target
);

    logic [CW-1:0] width;
    logic [CW-1:0] width_nxt;
    logic [CW-1:0] diff;

    // Within one step of the target we land exactly on it, so the ramp never overshoots.
    always_comb begin
        diff      = (target >= width) ? (target - width) : (width - target);
        width_nxt = target;
        if (STEP_CYC != 0 && 32'(diff) > STEP_CYC) begin
            width_nxt = (target > width) ? (width + CW'(STEP_CYC))
                                         : (width - CW'(STEP_CYC));
        end
    end

    assign at_target = (width == target);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            width <= CW'(REST_CYC);
            pwm   <= 1'b0;
        end else begin
            pwm <= (frame_cnt < width);
            if (frame_wrap) begin
                width <= width_nxt;
            end
        end
    end

endmodule

// File: rtl/servo_array_ctrl.sv
// Multi-channel gate servo driver: decodes position/storage bytes, opens the matching
// gate, and drives slew-limited hobby-servo PWM with an optional auto-close hold timer.
module servo_array_ctrl
    import servo_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned PERIOD_CYC  = DEF_PERIOD_CYC,
    parameter int unsigned OPEN_CYC    = DEF_OPEN_CYC,
    parameter int unsigned REST_CYC    = DEF_REST_CYC,
    parameter int unsigned STEP_CYC    = DEF_STEP_CYC,
    parameter logic [15:0] MATCH_MASK  = DEF_MATCH_MASK,
    parameter int unsigned HOLD_FRAMES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    servo_array_ctrl_if.slave rx,
    output logic [N_CH-1:0]   servo,
    output logic              busy,
    output logic              cmd_err
);

    localparam int unsigned CW = $clog2(PERIOD_CYC);
    localparam int unsigned HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    cmd_kind_e       kind;
    logic            pos_wr;
    logic            sto_wr;
    logic [4:0]      pos_reg;
    logic [6:0]      sto_reg;
    logic [31:0]     mask_ext;
    logic            match;
    logic [2:0]      ch_sel;
    logic            expired;
    logic [HW-1:0]   hold_cnt;
    logic [CW-1:0]   frame_cnt;
    logic            frame_wrap;
    logic [N_CH-1:0] at_tgt;

    assign kind   = rx.rx_valid ? classify(rx.rx_data) : CMD_NONE;
    assign pos_wr = (kind == CMD_POS);
    assign sto_wr = (kind == CMD_STO);

    // Mask is widened so pos_reg==16 indexes a zero bit rather than falling off the end.
    assign mask_ext = {16'h0000, MATCH_MASK};
    assign match    = (sto_reg == (7'(pos_reg) + 7'(STO_OFS))) && mask_ext[pos_reg];
    assign ch_sel   = 3'((pos_reg - 5'd1) >> 2);

    assign frame_wrap = (frame_cnt == CW'(PERIOD_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_reg <= '0;
            sto_reg <= '0;
            cmd_err <= 1'b0;
        end else begin
            cmd_err <= (kind == CMD_ERR);
            if (pos_wr) pos_reg <= rx.rx_data[4:0];
            if (sto_wr) sto_reg <= rx.rx_data[6:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_wrap ? '0 : (frame_cnt + CW'(1));
        end
    end

    // Any register write restarts the hold; a write in the wrap cycle wins over the increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            expired  <= 1'b0;
        end else if (pos_wr || sto_wr) begin
            hold_cnt <= '0;
            expired  <= 1'b0;
        end else if (HOLD_FRAMES != 0 && frame_wrap && match && !expired) begin
            hold_cnt <= hold_cnt + HW'(1);
            if (32'(hold_cnt) + 1 == HOLD_FRAMES) begin
                expired <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CW-1:0] target;

        assign target = (match && !expired && ch_sel == 3'(i)) ? CW'(OPEN_CYC) : CW'(REST_CYC);

        servo_pwm_channel #(
            .CW       (CW),
            .REST_CYC (REST_CYC),
            .STEP_CYC (STEP_CYC)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .frame_cnt  (frame_cnt),
            .frame_wrap (frame_wrap),
            .target     (target),
            .pwm        (servo[i]),
            .at_target  (at_tgt[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else begin
            busy <= ~&at_tgt;
        end
    end

endmodule
